// File: rtl/apple_controller_pkg.sv
// Shared types and defaults for the apple sequencer: FSM encoding, geometry, LFSR seed.
// Pure declarations; no latency or backpressure of its own.
package apple_controller_pkg;

    localparam int          DEF_BIT       = 10;
    localparam int          DEF_SIZE      = 10;
    localparam int          DEF_COLS      = 64;
    localparam int          DEF_ROWS      = 48;
    localparam int          DEF_MAX_TRIES = 8;
    localparam logic [15:0] DEF_SEED      = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        COMMIT = 2'd2,
        ACTIVE = 2'd3
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/apple_controller_if.sv
// Game-side bundle for the apple sequencer: control pulses and head position in, sprite state out.
// Wires only; the slave side registers every output it drives.
interface apple_controller_if #(
    parameter int BIT = 10
);
    logic           game_start;
    logic           game_over;
    logic           frame_tick;
    logic [BIT-1:0] head_x;
    logic [BIT-1:0] head_y;
    logic [BIT-1:0] apple_x;
    logic [BIT-1:0] apple_y;
    logic           apple_valid;
    logic           eaten;
    logic [7:0]     score;

    modport master (
        output game_start, game_over, frame_tick, head_x, head_y,
        input  apple_x, apple_y, apple_valid, eaten, score
    );

    modport slave (
        input  game_start, game_over, frame_tick, head_x, head_y,
        output apple_x, apple_y, apple_valid, eaten, score
    );
endinterface

// File: rtl/apple_controller_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, advancing every clock.
// Latency: q is the registered state; no backpressure, never stalls.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = {state_q[14:0], state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= SEED;
        else        state_q <= state_d;
    end

    assign q = state_q;

endmodule

// File: rtl/apple_controller.sv
// Apple sprite sequencer: random cell search, frame-aligned commit, hit detection, scoring.
// Latency: eaten one clk after the hit frame_tick; no backpressure, frame_tick paces all updates.
module apple_controller
    import apple_controller_pkg::*;
#(
    parameter int          BIT       = DEF_BIT,
    parameter int          SIZE      = DEF_SIZE,
    parameter int          COLS      = DEF_COLS,
    parameter int          ROWS      = DEF_ROWS,
    parameter int          MAX_TRIES = DEF_MAX_TRIES,
    parameter logic [15:0] SEED      = DEF_SEED
) (
    input  logic               clk,
    input  logic               rst_n,
    apple_controller_if.slave  bus
);

    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    logic [15:0]    lfsr_q;
    logic [3:0]     lfsr_unused;

    state_t         state_q,       state_d;
    logic [TRY_W-1:0] try_cnt_q,   try_cnt_d;
    logic [BIT-1:0] cand_x_q,      cand_x_d;
    logic [BIT-1:0] cand_y_q,      cand_y_d;
    logic [BIT-1:0] apple_x_q,     apple_x_d;
    logic [BIT-1:0] apple_y_q,     apple_y_d;
    logic           apple_valid_q, apple_valid_d;
    logic           eaten_q,       eaten_d;
    logic [7:0]     score_q,       score_d;

    logic [BIT-1:0] cand_px;
    logic [BIT-1:0] cand_py;
    logic           cand_ok;
    logic           hit;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr_q)
    );

    assign lfsr_unused = lfsr_q[15:12];

    // Constant multiply by SIZE reduces to shift/add logic.
    always_comb begin
        cand_px = BIT'((32'(lfsr_q[5:0]) % 32'(COLS)) * 32'(SIZE));
        cand_py = BIT'(32'(lfsr_q[11:6]) * 32'(SIZE));
        cand_ok = (32'(lfsr_q[11:6]) < 32'(ROWS)) &&
                  !((cand_px == bus.head_x) && (cand_py == bus.head_y));
        hit     = (bus.head_x == apple_x_q) && (bus.head_y == apple_y_q);
    end

    always_comb begin
        state_d       = state_q;
        try_cnt_d     = try_cnt_q;
        cand_x_d      = cand_x_q;
        cand_y_d      = cand_y_q;
        apple_x_d     = apple_x_q;
        apple_y_d     = apple_y_q;
        apple_valid_d = apple_valid_q;
        eaten_d       = 1'b0;
        score_d       = score_q;

        if (bus.game_start) begin
            score_d       = 8'd0;
            apple_valid_d = 1'b0;
            try_cnt_d     = '0;
            state_d       = SEARCH;
        end else if (!bus.game_over) begin
            case (state_q)
                IDLE: ;
                SEARCH: begin
                    if (cand_ok) begin
                        cand_x_d  = cand_px;
                        cand_y_d  = cand_py;
                        try_cnt_d = '0;
                        state_d   = COMMIT;
                    end else if (try_cnt_q == TRY_W'(MAX_TRIES - 1)) begin
                        // Fallback cell is taken even when the head sits on it.
                        cand_x_d  = '0;
                        cand_y_d  = '0;
                        try_cnt_d = '0;
                        state_d   = COMMIT;
                    end else begin
                        try_cnt_d = try_cnt_q + TRY_W'(1);
                    end
                end
                COMMIT: begin
                    if (bus.frame_tick) begin
                        apple_x_d     = cand_x_q;
                        apple_y_d     = cand_y_q;
                        apple_valid_d = 1'b1;
                        state_d       = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (bus.frame_tick && hit) begin
                        eaten_d       = 1'b1;
                        score_d       = sat_inc8(score_q);
                        apple_valid_d = 1'b0;
                        state_d       = SEARCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            try_cnt_q     <= '0;
            cand_x_q      <= '0;
            cand_y_q      <= '0;
            apple_x_q     <= '0;
            apple_y_q     <= '0;
            apple_valid_q <= 1'b0;
            eaten_q       <= 1'b0;
            score_q       <= 8'd0;
        end else begin
            state_q       <= state_d;
            try_cnt_q     <= try_cnt_d;
            cand_x_q      <= cand_x_d;
            cand_y_q      <= cand_y_d;
            apple_x_q     <= apple_x_d;
            apple_y_q     <= apple_y_d;
            apple_valid_q <= apple_valid_d;
            eaten_q       <= eaten_d;
            score_q       <= score_d;
        end
    end

    assign bus.apple_x     = apple_x_q;
    assign bus.apple_y     = apple_y_q;
    assign bus.apple_valid = apple_valid_q;
    assign bus.eaten       = eaten_q;
    assign bus.score       = score_q;

endmodule

// File: tb/tb_apple_controller.sv
// Directed bench for apple_controller: reset, search/commit timing, rejection, hits, saturation, freeze.
module tb_apple_controller;
    import apple_controller_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    apple_controller_if #(.BIT(10)) bus ();

    apple_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference LFSR: x^16+x^14+x^13+x^11+1, reset to 16'hACE1.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ft();
        bus.frame_tick = 1'b1;
        tick();
        bus.frame_tick = 1'b0;
    endtask

    // Entered just after the edge that put the DUT into SEARCH; forces the
    // first n_force candidates to be rejected by parking the head on them.
    task automatic do_search(input int n_force, output logic [9:0] ex, output logic [9:0] ey);
        int         t;
        bit         done;
        bit         rej;
        logic [5:0] xc;
        logic [5:0] yc;
        logic [9:0] px;
        logic [9:0] py;
        t    = 0;
        done = 1'b0;
        ex   = '0;
        ey   = '0;
        while (!done) begin
            xc = m_lfsr[5:0];
            yc = m_lfsr[11:6];
            px = 10'(xc) * 10'd10;
            py = 10'(yc) * 10'd10;
            if (t < n_force && yc < 6'd48) begin
                bus.head_x = px;
                bus.head_y = py;
            end
            rej = (yc >= 6'd48) || (px == bus.head_x && py == bus.head_y);
            tick();
            if (!rej) begin
                ex   = px;
                ey   = py;
                done = 1'b1;
            end else begin
                t++;
                if (t == 8) done = 1'b1;
            end
        end
    endtask

    logic [9:0] ex, ey;

    initial begin
        rst_n          = 1'b0;
        bus.game_start = 1'b0;
        bus.game_over  = 1'b0;
        bus.frame_tick = 1'b0;
        bus.head_x     = '0;
        bus.head_y     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", bus.apple_valid, 0);
        chk("rst_score", bus.score, 0);
        chk("rst_eaten", bus.eaten, 0);
        chk("rst_apple_x", bus.apple_x, 0);
        rst_n = 1'b1;
        chk("rst_lfsr", dut.lfsr_q, 16'hACE1);
        chk("rst_state", dut.state_q, IDLE);

        pulse_ft();
        chk("idle_ft_valid", bus.apple_valid, 0);
        chk("idle_ft_state", dut.state_q, IDLE);
        chk("lfsr_track", dut.lfsr_q, m_lfsr);

        // First apple with head at the origin.
        bus.game_start = 1'b1;
        tick();
        bus.game_start = 1'b0;
        chk("start_state", dut.state_q, SEARCH);
        do_search(0, ex, ey);
        chk("commit_state", dut.state_q, COMMIT);
        repeat (3) tick();
        chk("commit_no_valid", bus.apple_valid, 0);
        pulse_ft();
        chk("first_valid", bus.apple_valid, 1);
        chk("first_x", bus.apple_x, ex);
        chk("first_y", bus.apple_y, ey);
        chk("first_x_grid", bus.apple_x % 10, 0);
        chk("first_x_range", bus.apple_x < 640, 1);
        chk("first_y_range", bus.apple_y < 480, 1);

        // Head crosses the apple mid-frame only.
        bus.head_x = bus.apple_x;
        bus.head_y = bus.apple_y;
        repeat (3) tick();
        chk("midframe_eaten", bus.eaten, 0);
        bus.head_x = bus.apple_x + 10'd10;
        pulse_ft();
        chk("passby_eaten", bus.eaten, 0);
        chk("passby_valid", bus.apple_valid, 1);
        chk("passby_score", bus.score, 0);

        bus.head_x = bus.apple_x;
        pulse_ft();
        chk("hit_eaten", bus.eaten, 1);
        chk("hit_score", bus.score, 1);
        chk("hit_valid", bus.apple_valid, 0);
        chk("hit_state", dut.state_q, SEARCH);

        // One forced reject, then the model's next candidate.
        do_search(1, ex, ey);
        chk("eaten_one_clk", bus.eaten, 0);
        pulse_ft();
        chk("rej1_x", bus.apple_x, ex);
        chk("rej1_y", bus.apple_y, ey);
        chk("rej1_ne_head", (bus.apple_x == bus.head_x) && (bus.apple_y == bus.head_y), 0);

        // All tries rejected: fallback to (0,0).
        bus.head_x = bus.apple_x;
        bus.head_y = bus.apple_y;
        pulse_ft();
        chk("hit2_score", bus.score, 2);
        do_search(8, ex, ey);
        pulse_ft();
        chk("fallback_x", bus.apple_x, 0);
        chk("fallback_y", bus.apple_y, 0);
        chk("fallback_valid", bus.apple_valid, 1);

        // Drive score up to saturation.
        for (int i = 0; i < 253; i++) begin
            bus.head_x = bus.apple_x;
            bus.head_y = bus.apple_y;
            pulse_ft();
            repeat (9) tick();
            pulse_ft();
        end
        chk("preload_score", bus.score, 255);
        chk("preload_valid", bus.apple_valid, 1);

        bus.head_x = bus.apple_x;
        bus.head_y = bus.apple_y;
        pulse_ft();
        chk("sat_eaten", bus.eaten, 1);
        chk("sat_score", bus.score, 255);
        do_search(0, ex, ey);
        pulse_ft();
        chk("sat_apple_x", bus.apple_x, ex);
        chk("sat_apple_y", bus.apple_y, ey);

        // Frozen by game_over with the head on the apple.
        bus.game_over = 1'b1;
        bus.head_x    = bus.apple_x;
        bus.head_y    = bus.apple_y;
        for (int i = 0; i < 3; i++) begin
            pulse_ft();
            chk("over_eaten", bus.eaten, 0);
            tick();
        end
        chk("over_score", bus.score, 255);
        chk("over_valid", bus.apple_valid, 1);
        chk("over_x", bus.apple_x, ex);
        chk("over_y", bus.apple_y, ey);
        chk("over_state", dut.state_q, ACTIVE);

        // game_start beats a coincident frame_tick + hit, even under game_over.
        bus.game_start = 1'b1;
        bus.frame_tick = 1'b1;
        tick();
        bus.game_start = 1'b0;
        bus.frame_tick = 1'b0;
        chk("restart_score", bus.score, 0);
        chk("restart_eaten", bus.eaten, 0);
        chk("restart_valid", bus.apple_valid, 0);
        chk("restart_state", dut.state_q, SEARCH);

        // Back into ACTIVE with a nonzero score, then reset asynchronously.
        bus.game_over = 1'b0;
        do_search(0, ex, ey);
        pulse_ft();
        bus.head_x = bus.apple_x;
        bus.head_y = bus.apple_y;
        pulse_ft();
        chk("pre_rst_score", bus.score, 1);
        do_search(0, ex, ey);
        pulse_ft();
        chk("pre_rst_state", dut.state_q, ACTIVE);
        chk("pre_rst_x", bus.apple_x, ex);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.apple_valid, 0);
        chk("arst_score", bus.score, 0);
        chk("arst_x", bus.apple_x, 0);
        chk("arst_y", bus.apple_y, 0);
        chk("arst_eaten", bus.eaten, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("arst_state", dut.state_q, IDLE);
        chk("arst_lfsr", dut.lfsr_q, 16'hACE1);
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
